// File: rtl/frogger_pixel_coder.sv
// frogger_pixel_coder
//
// Produces the 6-bit colour code for every scan pixel. The playfield
// background bands (HUD, river, median, road with lane stripes, start strip)
// are composited with the frog sprite, which comes from an external
// synchronous sprite ROM. A small per-frame state machine blinks the frog
// while it dies and then hides it.
//
// Timing: a pixel presented on DrawX/DrawY with pix_valid in cycle n appears
// on colorcode/code_valid in cycle n+2.
//   Stage 1 registers the ROM address, the in-sprite flag, the background
//   code and the valid bit.
//   The ROM returns the addressed code one cycle after rom_addr.
//   Stage 2 registers the composited result.
//
// Valid semantics: pix_valid qualifies DrawX/DrawY in the same cycle. There
// is no ready/backpressure path; the pipeline never stalls. code_valid is
// pix_valid delayed by exactly two cycles, gaps included. While code_valid
// is low, colorcode holds the HUD/border code 1.
//
// Frog position and facing are latched only on frame_start, so the sprite
// never tears within a frame. The death FSM also advances only on
// frame_start, so sprite visibility changes only at frame boundaries.
//
// Optional feature, macro FROG_MIRROR_EN:
//   When defined, frog_face_left (latched with the position) mirrors the
//   sprite horizontally by reversing the dx part of the ROM address.
//   When undefined, frog_face_left is ignored.
//
// Ports:
//   Clk            in   system clock
//   Reset_n        in   asynchronous active-low reset
//   frame_start    in   one-cycle pulse at start of vertical blank
//   pix_valid      in   DrawX/DrawY valid this cycle
//   DrawX, DrawY   in   scan column / row (10 bits each)
//   frog_x, frog_y in   frog top-left corner (10 bits each)
//   frog_face_left in   frog facing left (mirror feature only)
//   frog_dead      in   level, frog has been hit
//   rom_addr       out  sprite ROM address {dy, dx}
//   rom_data       in   sprite ROM code, valid one cycle after rom_addr
//   colorcode      out  code to the colour mapper
//   code_valid     out  colorcode valid
module frogger_pixel_coder #(
  parameter int          FROG_SIZE    = 32,
  parameter logic [5:0]  TRANSP_CODE  = 6'h3F,
  parameter int          DEATH_FRAMES = 60,
  parameter int          BLINK_FRAMES = 8,
  localparam int         AW           = $clog2(FROG_SIZE)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic [9:0]    frog_x,
  input  logic [9:0]    frog_y,
  input  logic          frog_face_left,
  input  logic          frog_dead,
  output logic [2*AW-1:0] rom_addr,
  input  logic [5:0]    rom_data,
  output logic [5:0]    colorcode,
  output logic          code_valid
);

  localparam int         FW     = $clog2(DEATH_FRAMES + 1);
  localparam int         BW     = $clog2(BLINK_FRAMES + 1);
  localparam logic [9:0] SIZE10 = 10'(FROG_SIZE);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    DYING  = 2'd1,
    HIDDEN = 2'd2
  } death_state_e;

  // ---------------------------------------------------------------------
  // Frame-rate position latch
  // ---------------------------------------------------------------------
  logic [9:0] fx_q;
  logic [9:0] fy_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fx_q <= '0;
      fy_q <= '0;
    end else if (frame_start) begin
      fx_q <= frog_x;
      fy_q <= frog_y;
    end
  end

  // ---------------------------------------------------------------------
  // Death / blink FSM
  // ---------------------------------------------------------------------
  death_state_e  state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          visible;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ALIVE;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      case (state_q)
        ALIVE: begin
          if (frog_dead) begin
            state_d     = DYING;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
          end
        end
        DYING: begin
          // frog_dead is deliberately ignored until the animation ends.
          if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
          if (frame_cnt_q == FW'(DEATH_FRAMES - 1)) begin
            state_d     = HIDDEN;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        HIDDEN: begin
          if (!frog_dead) state_d = ALIVE;
        end
        default: state_d = ALIVE;
      endcase
    end
  end

  always_comb begin
    visible = 1'b0;
    case (state_q)
      ALIVE:   visible = 1'b1;
      DYING:   visible = ~phase_q;
      default: visible = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 1: sprite offset, ROM address, background band
  // ---------------------------------------------------------------------
  logic [9:0]    dx;
  logic [9:0]    dy;
  logic          in_frog;
  logic [AW-1:0] dx_sel;
  logic [5:0]    bg;

  // Unsigned wrap makes pixels left of / above the frog look far away.
  assign dx      = DrawX - fx_q;
  assign dy      = DrawY - fy_q;
  assign in_frog = (dx < SIZE10) && (dy < SIZE10);

`ifdef FROG_MIRROR_EN
  logic face_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      face_q <= 1'b0;
    end else if (frame_start) begin
      face_q <= frog_face_left;
    end
  end

  // FROG_SIZE is a power of two, so FROG_SIZE-1-dx is a bitwise invert.
  assign dx_sel = face_q ? ~dx[AW-1:0] : dx[AW-1:0];
`else
  logic unused_face_left;

  assign unused_face_left = frog_face_left;
  assign dx_sel           = dx[AW-1:0];
`endif

  always_comb begin
    bg = 6'd1;
    if (DrawX >= 10'd640 || DrawY >= 10'd480) begin
      bg = 6'd1;
    end else if (DrawY < 10'd32) begin
      bg = 6'd1;
    end else if (DrawY < 10'd224) begin
      bg = 6'd4;
    end else if (DrawY < 10'd256) begin
      bg = 6'd9;
    end else if (DrawY < 10'd448) begin
      // Dashed lane marking on the first row of each 32-row lane.
      bg = (DrawY[4:0] == 5'd0 && DrawX[4]) ? 6'd5 : 6'd13;
    end else begin
      bg = 6'd12;
    end
  end

  logic       s1_valid;
  logic       s1_in_frog;
  logic [5:0] s1_bg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid   <= 1'b0;
      s1_in_frog <= 1'b0;
      s1_bg      <= 6'd1;
      rom_addr   <= '0;
    end else begin
      s1_valid   <= pix_valid;
      s1_in_frog <= in_frog;
      s1_bg      <= bg;
      rom_addr   <= {dy[AW-1:0], dx_sel};
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: composite sprite over background
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      code_valid <= 1'b0;
      colorcode  <= 6'd1;
    end else begin
      code_valid <= s1_valid;
      if (!s1_valid) begin
        colorcode <= 6'd1;
      end else if (s1_in_frog && visible && rom_data != TRANSP_CODE) begin
        colorcode <= rom_data;
      end else begin
        colorcode <= s1_bg;
      end
    end
  end

endmodule

// File: tb/tb_frogger_pixel_coder.sv
// Testbench for frogger_pixel_coder: directed scans from the test plan plus
// randomized pixel streams, checked against a frame-level model of the
// playfield, the frog sprite and the death animation.
module tb_frogger_pixel_coder;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic       frog_face_left;
  logic       frog_dead;
  logic [9:0] rom_addr;
  logic [5:0] rom_data;
  logic [5:0] colorcode;
  logic       code_valid;

  int total = 0;
  int bad   = 0;
  int rom_mode = 0;

  // {code_valid, colorcode} expected two cycles after each input cycle.
  logic [6:0] exp_q[$];

  // Model state: latched position/facing, alive=0 / dying=1 / hidden=2,
  // frames elapsed since the frog started dying.
  int m_fx, m_fy, m_face, m_state, m_since;

`ifdef FROG_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  frogger_pixel_coder dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .frog_x         (frog_x),
    .frog_y         (frog_y),
    .frog_face_left (frog_face_left),
    .frog_dead      (frog_dead),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .colorcode      (colorcode),
    .code_valid     (code_valid)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- sprite ROM ----------------
  // The address is a register in the DUT; the code it selects is what the
  // DUT samples at the following edge.
  always_comb begin
    if (rom_mode == 0) rom_data = (rom_addr[4:0] == 5'd0) ? 6'h3F : 6'd2;
    else               rom_data = 6'((int'(rom_addr) * 37 + 11) % 64);
  end

  // ---------------- reference model ----------------
  function automatic int rom_fn(int a);
    if (rom_mode == 0) return (a % 32 == 0) ? 63 : 2;
    return (a * 37 + 11) % 64;
  endfunction

  function automatic int bg_code(int x, int y);
    if (x >= 640 || y >= 480) return 1;
    if (y < 32)  return 1;
    if (y < 224) return 4;
    if (y < 256) return 9;
    if (y < 448) return ((y % 32 == 0) && ((x / 16) % 2 == 1)) ? 5 : 13;
    return 12;
  endfunction

  function automatic bit m_visible();
    if (m_state == 0) return 1'b1;
    if (m_state == 1) return ((m_since / 8) % 2) == 0;
    return 1'b0;
  endfunction

  function automatic int model_addr(int x, int y);
    int dx, dy, col;
    dx  = (x - m_fx) & 1023;
    dy  = (y - m_fy) & 1023;
    col = (MIRROR && m_face != 0) ? 31 - (dx % 32) : dx % 32;
    return (dy % 32) * 32 + col;
  endfunction

  function automatic int model_code(int x, int y);
    int dx, dy, a;
    dx = (x - m_fx) & 1023;
    dy = (y - m_fy) & 1023;
    a  = model_addr(x, y);
    if (dx < 32 && dy < 32 && m_visible() && rom_fn(a) != 63) return rom_fn(a);
    return bg_code(x, y);
  endfunction

  task automatic model_reset();
    m_fx = 0; m_fy = 0; m_face = 0; m_state = 0; m_since = 0;
  endtask

  task automatic model_frame();
    m_fx   = int'(frog_x);
    m_fy   = int'(frog_y);
    m_face = int'(frog_face_left);
    case (m_state)
      0: if (frog_dead) begin m_state = 1; m_since = 0; end
      1: begin
        m_since++;
        if (m_since == 60) m_state = 2;
      end
      default: if (!frog_dead) m_state = 0;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the inputs already applied; sampled on the falling edge.
  task automatic tick(input logic [6:0] e, input bit chk_addr, input logic [9:0] e_addr);
    logic [6:0] ev;
    exp_q.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    if (chk_addr) check("rom_addr", 16'(rom_addr), 16'(e_addr));
    ev = exp_q.pop_front();
    check("valid_code", 16'({code_valid, colorcode}), 16'(ev));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    tick({1'b0, 6'd1}, 1'b0, 10'd0);
  endtask

  task automatic pix(input int x, input int y);
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick({1'b1, 6'(model_code(x, y))}, 1'b1, 10'(model_addr(x, y)));
  endtask

  task automatic pix_chk(input int x, input int y, input logic [5:0] code, input logic [9:0] addr);
    frame_start = 1'b0;
    pix_valid   = 1'b1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick({1'b1, code}, 1'b1, addr);
  endtask

  task automatic pix_exp(input int x, input int y, input logic [5:0] code);
    pix_chk(x, y, code, 10'(model_addr(x, y)));
  endtask

  task automatic frame();
    frame_start = 1'b1;
    pix_valid   = 1'b0;
    tick({1'b0, 6'd1}, 1'b0, 10'd0);
    frame_start = 1'b0;
    model_frame();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 16'(code_valid), 16'd0);
    check({tag, "_code"},  16'(colorcode),  16'd1);
    check({tag, "_addr"},  16'(rom_addr),   16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b1;
    frame_start = 1'b0; pix_valid = 1'b0;
    DrawX = '0; DrawY = '0; frog_x = '0; frog_y = '0;
    frog_face_left = 1'b0; frog_dead = 1'b0;
    model_reset();
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("por");
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      pix_valid = ~pix_valid;
      check_reset_outputs("por_hold");
    end
    @(negedge Clk);
    Reset_n   = 1'b1;
    pix_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back({1'b0, 6'd1});

    // First valid code two cycles after the first pix_valid; frog at (0,0).
    idle(); idle();
    pix(10, 10);
    idle(); idle();

    // Background bands and lane stripe.
    pix_exp(16, 256, 6'd5);
    pix_exp(15, 256, 6'd13);
    pix_exp(300, 100, 6'd4);
    pix_exp(700, 100, 6'd1);
    pix_exp(40, 20, 6'd1);
    pix_exp(50, 230, 6'd9);
    pix_exp(639, 479, 6'd12);
    pix_exp(640, 460, 6'd1);
    pix_exp(50, 480, 6'd1);
    idle();

    // Sprite scan across frog at (100,300); ROM transparent at dx=0.
    frog_x = 10'd100; frog_y = 10'd300;
    frame();
    idle();
    for (int x = 99; x <= 132; x++)
      pix_exp(x, 310, (x == 99 || x == 100 || x == 132) ? 6'd13 : 6'd2);
    idle();

    // Mid-frame position change must wait for frame_start.
    frog_x = 10'd300;
    pix_exp(101, 310, 6'd2);
    pix_exp(301, 310, 6'd13);
    frame();
    pix_exp(101, 310, 6'd13);
    pix_exp(301, 310, 6'd2);
    idle();

    // Facing left: dx=0, dy=3 mirrors to dx=31 when the feature is built in.
    frog_x = 10'd50; frog_y = 10'd40; frog_face_left = 1'b1;
    frame();
    pix_chk(50, 43, MIRROR ? 6'd2 : 6'd4, MIRROR ? 10'd127 : 10'd96);
    frog_face_left = 1'b0;
    frame();
    pix_chk(50, 43, 6'd4, 10'd96);
    idle();

    // Death animation: blink every 8 frames, hidden after 60 frames.
    frog_x = 10'd200; frog_y = 10'd100;
    frame();
    pix(201, 105);
    frog_dead = 1'b1;
    pix(205, 105);
    frame();
    for (int f = 0; f < 72; f++) begin
      pix(200 + $urandom_range(1, 31), 100 + $urandom_range(0, 31));
      pix(200 + $urandom_range(1, 31), 100 + $urandom_range(0, 31));
      idle();
      if (f >= 10 && f <= 50) frog_dead = 1'($urandom_range(0, 1));
      else frog_dead = (f < 64);
      frame();
    end
    pix(210, 110);
    idle();

    // Randomized frames with random frog placement, facing and gaps.
    rom_mode = 1;
    for (int fr = 0; fr < 8; fr++) begin
      frog_x = 10'($urandom_range(0, 660));
      frog_y = 10'($urandom_range(0, 500));
      frog_face_left = 1'($urandom_range(0, 1));
      frame();
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        else if ($urandom_range(0, 4) == 0)
          pix($urandom_range(0, 799), $urandom_range(0, 524));
        else
          pix((int'(frog_x) + $urandom_range(0, 40) - 4) & 1023,
              (int'(frog_y) + $urandom_range(0, 40) - 4) & 1023);
      end
    end

    // Asynchronous reset in the middle of a pixel stream.
    frog_x = 10'd100; frog_y = 10'd200;
    frame();
    pix(110, 210); pix(111, 210); pix(112, 211);
    pix_valid = 1'b1;
    #1 Reset_n = 1'b0;
    #1 check_reset_outputs("async");
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      pix_valid = ~pix_valid;
      check_reset_outputs("async_hold");
    end
    Reset_n   = 1'b1;
    pix_valid = 1'b0;
    model_reset();
    exp_q.delete();
    exp_q.push_back({1'b0, 6'd1});
    idle();
    pix(5, 5);
    pix(6, 7);
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frogger_pixel_coder.md
Name: frogger_pixel_coder

Overview:
Generates the 6-bit per-pixel colour code consumed by the colour mapper, from VGA scan coordinates.
- Composites the playfield background bands (HUD, river, median, road, start strip) with the frog sprite, which is fetched from a synchronous sprite ROM.
- Pipelined at 2 cycles, with a per-frame death-blink state machine.
- Sits between the VGA controller / game logic and the colour mapper.

Parameters:
- FROG_SIZE, 32: frog sprite edge in pixels. Must be a power of two; ROM address = {dy, dx}.
- TRANSP_CODE, 6'h3F: sprite ROM code treated as transparent.
- DEATH_FRAMES, 60: frames spent in DYING.
- BLINK_FRAMES, 8: frames per blink half-period.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid  in  1  DrawX/DrawY valid this cycle
- DrawX  in  10  scan column
- DrawY  in  10  scan row
- frog_x  in  10  frog top-left column
- frog_y  in  10  frog top-left row
- frog_face_left  in  1  frog facing left (used only with the optional feature)
- frog_dead  in  1  level, frog has been hit
- rom_addr  out  10  sprite ROM address, {dy[4:0],dx[4:0]}
- rom_data  in  6  sprite ROM code; valid 1 cycle after rom_addr
- colorcode  out  6  code to the colour mapper
- code_valid  out  1  colorcode valid

Behaviour:
Reset (async, Reset_n=0):
- colorcode=6'd1, code_valid=0, rom_addr=0.
- Latched frog position = 0, FSM=ALIVE, all counters 0.
- Takes effect immediately, including mid-frame.
- Pipeline valid bits clear, so no stale code_valid appears after release.

Position latch:
- frog_x/frog_y sampled only on cycles with frame_start=1.
- Position is constant over a frame (no tearing).

Stage 1 (registered on every clock):
- dx = DrawX - fx_q, dy = DrawY - fy_q, 10-bit unsigned wrap.
- in_frog = (dx < FROG_SIZE) && (dy < FROG_SIZE). Negative offsets wrap large and fail the test.
- rom_addr = {dy[4:0],dx[4:0]}.
- Background code:
  - DrawX>=640 or DrawY>=480 → 1
  - y<32 → 1
  - 32..223 → 4
  - 224..255 → 9
  - 256..447 → 13, except 5 when DrawY[4:0]==0 && DrawX[4]==1 (lane stripe)
  - 448..479 → 12
- The valid bit is pipelined alongside.

Stage 2 (output register):
- colorcode = rom_data if stage-1 in_frog && frog_visible && rom_data!=TRANSP_CODE; otherwise the background code.
- code_valid = pix_valid delayed exactly 2 cycles.
- When code_valid=0, colorcode=6'd1.
- Gaps in pix_valid propagate unchanged; no stalls.

Death FSM (advances only on frame_start):
- ALIVE: visible=1. frog_dead=1 at a frame_start → DYING, frame_cnt=0, blink_cnt=0, phase=0.
- DYING:
  - visible = ~phase.
  - blink_cnt increments; at BLINK_FRAMES-1 it resets to 0 and phase toggles.
  - frame_cnt increments; at DEATH_FRAMES-1 → HIDDEN.
  - frog_dead is ignored in this state.
- HIDDEN: visible=0. frog_dead=0 at a frame_start → ALIVE.
- frog_dead asserting between frame_start pulses takes effect at the next frame_start.
- visible changes only at frame boundaries.

Optional Feature:
Macro FROG_MIRROR_EN.
- Defined: when frog_face_left=1 (latched on frame_start with position), rom_addr uses dx' = FROG_SIZE-1-dx[4:0], so the sprite is mirrored horizontally.
- Undefined: frog_face_left is ignored and dx is used unmirrored.

Test Plan:
1. Reset_n=0 mid-frame with pix_valid toggling → code_valid=0, colorcode=1 immediately. After release, the first code_valid appears 2 cycles after the first pix_valid.
2. frog at (100,300), frame_start, scan DrawY=310, DrawX=99..132, ROM returning 2 (TRANSP at dx=0) →
   - DrawX 99: code 13
   - DrawX 100: code 13 (transparent)
   - DrawX 101..131: code 2
   - DrawX 132: code 13
   - each 2 cycles after input.
3. DrawY=256, DrawX=16 → 5; DrawX=15 → 13. DrawY=100 → 4; DrawX=700 → 1.
4. frog_dead=1 before frame_start →
   - frames 0-7 visible, 8-15 hidden, 16-23 visible, and so on.
   - after 60 frames: HIDDEN.
   - drop frog_dead → visible from the next frame_start.
5. frog_x changed mid-frame without frame_start → the sprite does not move until the next frame_start.
6. (FROG_MIRROR_EN) frog_face_left=1, pixel dx=0, dy=3 → rom_addr={5'd3,5'd31}.
